cpu_addr_seq: RTL and testbench

Parametrised addressing-mode sequencer for the NES 6502 core; successor to the hard-wired IMM/ABS sequencing in the CPU controller. Fetches the opcode, walks the cycle-accurate address sequence for the group-01 modes (IMM, ZP, ZP,X, ABS, ABS,X, ABS,Y), drives the address bus, and owns the program counter. It presents one operand strobe per instruction to the execute/ALU stage. It also adds RDY stalling and page-cross handling.

---
 rtl/cpu_addr_seq_if.sv | 31 +++
 rtl/cpu_addr_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_addr_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_addr_seq_if.sv
// ---------------------------------------------------------------------------
// cpu_addr_seq_if
// Bus bundle between the 6502 addressing-mode sequencer and its surroundings.
//
//   master modport (the sequencer):
//     in : rdy, d_in, x_in, y_in
//     out: addr, pc, ir, operand, operand_valid, illegal
//   slave modport (memory / register file / execute stage): the reverse.
// ---------------------------------------------------------------------------
interface cpu_addr_seq_if;
    logic        rdy;
    logic [7:0]  d_in;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [7:0]  ir;
    logic [7:0]  operand;
    logic        operand_valid;
    logic        illegal;

    modport master (
        input  rdy, d_in, x_in, y_in,
        output addr, pc, ir, operand, operand_valid, illegal
    );

    modport slave (
        output rdy, d_in, x_in, y_in,
        input  addr, pc, ir, operand, operand_valid, illegal
    );
endinterface

// File: rtl/cpu_addr_seq.sv
// ---------------------------------------------------------------------------
// cpu_addr_seq
// Addressing-mode sequencer for the NES 6502 core. Fetches the opcode, walks
// the cycle-accurate address sequence for the group-01 modes (IMM, ZP, ZP,X,
// ABS, ABS,X, ABS,Y), drives the address bus, owns the program counter and
// gives the execute stage one operand strobe per instruction.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (wins over rdy)
//   bus  - cpu_addr_seq_if.master:
//          rdy (1 = advance, 0 = freeze), d_in (read data), x_in / y_in
//          (index registers), addr (address bus), pc, ir (latched opcode),
//          operand (= d_in), operand_valid (operand strobe), illegal
//          (unsupported addressing mode decoded)
//
// Parameters:
//   RESET_PC - program counter value after reset
//   ZP_BASE  - high address byte for zero-page accesses
//
// Build option:
//   PAGE_CROSS_CYCLE_EN - when defined, indexed absolute takes 4 cycles and a
//   fifth only on a page cross; when undefined it always takes 5 cycles.
// ---------------------------------------------------------------------------
module cpu_addr_seq #(
    parameter logic [15:0] RESET_PC = 16'h8000,
    parameter logic [7:0]  ZP_BASE  = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    cpu_addr_seq_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        IMM_T1  = 4'd1,
        ZP_T1   = 4'd2,
        ZP_T2   = 4'd3,
        ZPX_T1  = 4'd4,
        ZPX_T2  = 4'd5,
        ZPX_T3  = 4'd6,
        ABS_T1  = 4'd7,
        ABS_T2  = 4'd8,
        ABS_T3  = 4'd9,
        ABSI_T1 = 4'd10,
        ABSI_T2 = 4'd11,
        ABSI_T3 = 4'd12,
        ABSI_T4 = 4'd13
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] pc_r;
    logic [7:0]  ir_r;
    logic [7:0]  zp_r;
    logic [7:0]  lo_r;
    logic [7:0]  hi_r;
    logic [7:0]  ea_lo_r;
    logic        carry_r;
    logic        idx_x_r;     // 1: indexed absolute uses X, 0: uses Y

    logic [15:0] addr_s;
    logic        pc_inc_s;
    logic        valid_s;
    logic        illegal_s;
    logic [7:0]  idx_s;
    logic [8:0]  sum_s;

    // Index selection and 9-bit low-byte sum for indexed absolute.
    always_comb begin
        idx_s = 8'h00;
        if (idx_x_r) begin
            idx_s = bus.x_in;
        end else begin
            idx_s = bus.y_in;
        end
        sum_s = {1'b0, lo_r} + {1'b0, idx_s};
    end

    // Next-state decode, address bus mux and strobes.
    always_comb begin
        state_nx_s = state_r;
        addr_s     = pc_r;
        pc_inc_s   = 1'b0;
        valid_s    = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            FETCH: begin
                pc_inc_s = 1'b1;
                // Only bbb selects the mode; cc belongs to the ALU decode.
                case (bus.d_in[4:2])
                    3'b010:  state_nx_s = IMM_T1;
                    3'b001:  state_nx_s = ZP_T1;
                    3'b101:  state_nx_s = ZPX_T1;
                    3'b011:  state_nx_s = ABS_T1;
                    3'b110:  state_nx_s = ABSI_T1;
                    3'b111:  state_nx_s = ABSI_T1;
                    default: begin
                        // Unsupported mode: opcode is skipped, keep fetching.
                        state_nx_s = FETCH;
                        illegal_s  = 1'b1;
                    end
                endcase
            end
            IMM_T1: begin
                pc_inc_s   = 1'b1;
                valid_s    = 1'b1;
                state_nx_s = FETCH;
            end
            ZP_T1: begin
                pc_inc_s   = 1'b1;
                state_nx_s = ZP_T2;
            end
            ZP_T2: begin
                addr_s     = {ZP_BASE, zp_r};
                valid_s    = 1'b1;
                state_nx_s = FETCH;
            end
            ZPX_T1: begin
                pc_inc_s   = 1'b1;
                state_nx_s = ZPX_T2;
            end
            ZPX_T2: begin
                // Dummy read at the unindexed zero-page address.
                addr_s     = {ZP_BASE, zp_r};
                state_nx_s = ZPX_T3;
            end
            ZPX_T3: begin
                addr_s     = {ZP_BASE, ea_lo_r};
                valid_s    = 1'b1;
                state_nx_s = FETCH;
            end
            ABS_T1: begin
                pc_inc_s   = 1'b1;
                state_nx_s = ABS_T2;
            end
            ABS_T2: begin
                pc_inc_s   = 1'b1;
                state_nx_s = ABS_T3;
            end
            ABS_T3: begin
                addr_s     = {hi_r, lo_r};
                valid_s    = 1'b1;
                state_nx_s = FETCH;
            end
            ABSI_T1: begin
                pc_inc_s   = 1'b1;
                state_nx_s = ABSI_T2;
            end
            ABSI_T2: begin
                pc_inc_s   = 1'b1;
                state_nx_s = ABSI_T3;
            end
            ABSI_T3: begin
                // Uncorrected high byte; a real access only when no carry.
                addr_s = {hi_r, ea_lo_r};
`ifdef PAGE_CROSS_CYCLE_EN
                if (carry_r) begin
                    state_nx_s = ABSI_T4;
                end else begin
                    valid_s    = 1'b1;
                    state_nx_s = FETCH;
                end
`else
                state_nx_s = ABSI_T4;
`endif
            end
            ABSI_T4: begin
`ifdef PAGE_CROSS_CYCLE_EN
                addr_s = {hi_r + 8'd1, ea_lo_r};
`else
                addr_s = {hi_r + {7'd0, carry_r}, ea_lo_r};
`endif
                valid_s    = 1'b1;
                state_nx_s = FETCH;
            end
            default: begin
                state_nx_s = FETCH;
            end
        endcase
    end

    // State, program counter and operand-address latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            ir_r    <= 8'hEA;
            zp_r    <= 8'h00;
            lo_r    <= 8'h00;
            hi_r    <= 8'h00;
            ea_lo_r <= 8'h00;
            carry_r <= 1'b0;
            idx_x_r <= 1'b0;
        end else if (bus.rdy) begin
            state_r <= state_nx_s;
            if (pc_inc_s) begin
                pc_r <= pc_r + 16'd1;
            end
            case (state_r)
                FETCH: begin
                    ir_r    <= bus.d_in;
                    idx_x_r <= bus.d_in[2];   // bbb=111 -> X, 110 -> Y
                end
                ZP_T1, ZPX_T1: zp_r <= bus.d_in;
                ZPX_T2:        ea_lo_r <= zp_r + bus.x_in;
                ABS_T1, ABSI_T1: lo_r <= bus.d_in;
                ABS_T2:        hi_r <= bus.d_in;
                ABSI_T2: begin
                    hi_r    <= bus.d_in;
                    ea_lo_r <= sum_s[7:0];
                    carry_r <= sum_s[8];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.addr          = addr_s;
    assign bus.pc            = pc_r;
    assign bus.ir            = ir_r;
    assign bus.operand       = bus.d_in;
    assign bus.operand_valid = valid_s & bus.rdy;
    assign bus.illegal       = illegal_s & bus.rdy;

endmodule

// File: tb/tb_cpu_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_addr_seq
// Directed bench for cpu_addr_seq. A 64 KiB byte array models memory and
// feeds d_in from addr. A second instance with RESET_PC=FFFF and ZP_BASE=03
// covers pc wrap and a non-zero zero-page base.
// ---------------------------------------------------------------------------
module tb_cpu_addr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] x_val = 8'h00;
    logic [7:0] y_val = 8'h00;
    logic [7:0] mem [0:65535];

    int checks   = 0;
    int failures = 0;

    cpu_addr_seq_if bus ();
    cpu_addr_seq_if bus2 ();

    assign bus.rdy   = rdy;
    assign bus.x_in  = x_val;
    assign bus.y_in  = y_val;
    assign bus.d_in  = mem[bus.addr];
    assign bus2.rdy  = rdy;
    assign bus2.x_in = x_val;
    assign bus2.y_in = y_val;
    assign bus2.d_in = mem[bus2.addr];

    cpu_addr_seq #(.RESET_PC(16'h8000), .ZP_BASE(8'h00)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    cpu_addr_seq #(.RESET_PC(16'hFFFF), .ZP_BASE(8'h03)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) begin
            mem[a[15:0]] = 8'hEA;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[16'h8000] = 8'h6D;
        mem[16'h8001] = 8'h34;
        mem[16'h8002] = 8'h12;
        rdy = 1'b1;
        do_reset();
        checks++; if (bus.addr !== 16'h8000) begin failures++; $display("FAIL reset_addr got=%h exp=8000", bus.addr); end
        checks++; if (bus.pc !== 16'h8000) begin failures++; $display("FAIL reset_pc got=%h exp=8000", bus.pc); end
        checks++; if (bus.ir !== 8'hEA) begin failures++; $display("FAIL reset_ir got=%h exp=EA", bus.ir); end
        checks++; if (bus.operand_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", bus.operand_valid); end
        tick();   // ABS_T1
        tick();   // ABS_T2
        checks++; if (bus.addr !== 16'h8002) begin failures++; $display("FAIL pre_reset_addr got=%h exp=8002", bus.addr); end
        // Reset mid-instruction while frozen: reset must still win.
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        #1;
        checks++; if (bus.addr !== 16'h8000) begin failures++; $display("FAIL midreset_addr got=%h exp=8000", bus.addr); end
        checks++; if (bus.ir !== 8'hEA) begin failures++; $display("FAIL midreset_ir got=%h exp=EA", bus.ir); end
        checks++; if (bus.operand_valid !== 1'b0) begin failures++; $display("FAIL midreset_ov got=%b exp=0", bus.operand_valid); end
        checks++; if (bus.pc !== 16'h8000) begin failures++; $display("FAIL midreset_pc got=%h exp=8000", bus.pc); end
    endtask

    task automatic test_imm();
        clear_mem();
        mem[16'h8000] = 8'h69;
        mem[16'h8001] = 8'h5A;
        do_reset();
        checks++; if (bus.addr !== 16'h8000 || bus.operand_valid !== 1'b0) begin failures++; $display("FAIL imm_c1 addr=%h ov=%b exp 8000/0", bus.addr, bus.operand_valid); end
        tick();
        checks++; if (bus.addr !== 16'h8001) begin failures++; $display("FAIL imm_c2_addr got=%h exp=8001", bus.addr); end
        checks++; if (bus.operand_valid !== 1'b1 || bus.operand !== 8'h5A) begin failures++; $display("FAIL imm_operand ov=%b op=%h exp 1/5A", bus.operand_valid, bus.operand); end
        checks++; if (bus.ir !== 8'h69) begin failures++; $display("FAIL imm_ir got=%h exp=69", bus.ir); end
        tick();
        checks++; if (bus.pc !== 16'h8002 || bus.addr !== 16'h8002 || bus.operand_valid !== 1'b0) begin failures++; $display("FAIL imm_next pc=%h addr=%h ov=%b exp 8002/8002/0", bus.pc, bus.addr, bus.operand_valid); end
    endtask

    task automatic test_zpx();
        logic [15:0] ea [4];
        ea = '{16'h8000, 16'h8001, 16'h00F0, 16'h0010};
        clear_mem();
        mem[16'h8000] = 8'h75;
        mem[16'h8001] = 8'hF0;
        mem[16'h0010] = 8'h33;
        mem[16'h0110] = 8'h99;
        x_val = 8'h20;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            checks++; if (bus.addr !== ea[i]) begin failures++; $display("FAIL zpx_addr c%0d got=%h exp=%h", i + 1, bus.addr, ea[i]); end
            checks++; if (bus.operand_valid !== (i == 3)) begin failures++; $display("FAIL zpx_ov c%0d got=%b exp=%b", i + 1, bus.operand_valid, (i == 3)); end
        end
        checks++; if (bus.operand !== 8'h33) begin failures++; $display("FAIL zpx_operand got=%h exp=33", bus.operand); end
        tick();
        checks++; if (bus.addr !== 16'h8002) begin failures++; $display("FAIL zpx_next got=%h exp=8002", bus.addr); end
        x_val = 8'h00;
    endtask

    task automatic test_abs_indexed();
        logic [15:0] ea [5];
        logic [7:0]  op_exp;
        int          n;
        // Three passes: ABS,X with page cross, ABS,X without, ABS,Y wrapping FF->00.
        for (int pass = 0; pass < 3; pass++) begin
            clear_mem();
            mem[16'h1310] = 8'h44;
            mem[16'h12F5] = 8'h55;
            mem[16'h00FE] = 8'h66;
            if (pass == 2) begin
                mem[16'h8000] = 8'h79;
                mem[16'h8001] = 8'hFF;
                mem[16'h8002] = 8'hFF;
                x_val = 8'h01;
                y_val = 8'hFF;
                ea = '{16'h8000, 16'h8001, 16'h8002, 16'hFFFE, 16'h00FE};
                n = 5;
                op_exp = 8'h66;
            end else begin
                mem[16'h8000] = 8'h7D;
                mem[16'h8001] = 8'hF0;
                mem[16'h8002] = 8'h12;
                y_val = 8'h00;
                if (pass == 0) begin
                    x_val = 8'h20;
                    ea = '{16'h8000, 16'h8001, 16'h8002, 16'h1210, 16'h1310};
                    n = 5;
                    op_exp = 8'h44;
                end else begin
                    x_val = 8'h05;
`ifdef PAGE_CROSS_CYCLE_EN
                    ea = '{16'h8000, 16'h8001, 16'h8002, 16'h12F5, 16'h0000};
                    n = 4;
`else
                    ea = '{16'h8000, 16'h8001, 16'h8002, 16'h12F5, 16'h12F5};
                    n = 5;
`endif
                    op_exp = 8'h55;
                end
            end
            do_reset();
            for (int i = 0; i < n; i++) begin
                if (i != 0) tick();
                checks++; if (bus.addr !== ea[i]) begin failures++; $display("FAIL absi%0d_addr c%0d got=%h exp=%h", pass, i + 1, bus.addr, ea[i]); end
                checks++; if (bus.operand_valid !== (i == n - 1)) begin failures++; $display("FAIL absi%0d_ov c%0d got=%b exp=%b", pass, i + 1, bus.operand_valid, (i == n - 1)); end
            end
            checks++; if (bus.operand !== op_exp) begin failures++; $display("FAIL absi%0d_operand got=%h exp=%h", pass, bus.operand, op_exp); end
            tick();
            checks++; if (bus.addr !== 16'h8003 || bus.operand_valid !== 1'b0) begin failures++; $display("FAIL absi%0d_next addr=%h ov=%b exp 8003/0", pass, bus.addr, bus.operand_valid); end
        end
        x_val = 8'h00;
        y_val = 8'h00;
    endtask

    task automatic test_rdy_stall();
        int pulses;
        clear_mem();
        mem[16'h8000] = 8'h6D;
        mem[16'h8001] = 8'h34;
        mem[16'h8002] = 8'h12;
        mem[16'h1234] = 8'h77;
        pulses = 0;
        do_reset();
        tick();   // ABS_T1
        tick();   // ABS_T2
        rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.operand_valid) pulses++;
            checks++; if (bus.addr !== 16'h8002 || bus.pc !== 16'h8002) begin failures++; $display("FAIL stall_hold c%0d addr=%h pc=%h exp 8002/8002", i, bus.addr, bus.pc); end
        end
        rdy = 1'b1;
        tick();   // ABS_T3
        checks++; if (bus.addr !== 16'h1234) begin failures++; $display("FAIL stall_ea got=%h exp=1234", bus.addr); end
        rdy = 1'b0;
        #1;
        checks++; if (bus.operand_valid !== 1'b0) begin failures++; $display("FAIL stall_ov_gated got=%b exp=0", bus.operand_valid); end
        rdy = 1'b1;
        #1;
        if (bus.operand_valid) pulses++;
        checks++; if (bus.operand !== 8'h77) begin failures++; $display("FAIL stall_operand got=%h exp=77", bus.operand); end
        tick();
        if (bus.operand_valid) pulses++;
        checks++; if (bus.addr !== 16'h8003) begin failures++; $display("FAIL stall_next got=%h exp=8003", bus.addr); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[16'h8000] = 8'h61;   // bbb=000
        mem[16'h8001] = 8'h71;   // bbb=100
        do_reset();
        checks++; if (bus.illegal !== 1'b1 || bus.addr !== 16'h8000) begin failures++; $display("FAIL illegal_c1 ill=%b addr=%h exp 1/8000", bus.illegal, bus.addr); end
        tick();
        checks++; if (bus.addr !== 16'h8001 || bus.pc !== 16'h8001) begin failures++; $display("FAIL illegal_c2 addr=%h pc=%h exp 8001/8001", bus.addr, bus.pc); end
        checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL illegal_c2_pulse got=%b exp=1", bus.illegal); end
        tick();
        checks++; if (bus.illegal !== 1'b0 || bus.addr !== 16'h8002 || bus.operand_valid !== 1'b0) begin failures++; $display("FAIL illegal_c3 ill=%b addr=%h ov=%b exp 0/8002/0", bus.illegal, bus.addr, bus.operand_valid); end
    endtask

    task automatic test_pc_wrap_zp();
        clear_mem();
        mem[16'hFFFF] = 8'h65;   // ZP
        mem[16'h0000] = 8'h40;
        mem[16'h0340] = 8'h99;
        do_reset();
        checks++; if (bus2.addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_c1 got=%h exp=FFFF", bus2.addr); end
        tick();
        checks++; if (bus2.addr !== 16'h0000 || bus2.pc !== 16'h0000) begin failures++; $display("FAIL wrap_c2 addr=%h pc=%h exp 0000/0000", bus2.addr, bus2.pc); end
        tick();
        checks++; if (bus2.addr !== 16'h0340 || bus2.operand_valid !== 1'b1 || bus2.operand !== 8'h99) begin failures++; $display("FAIL zp_c3 addr=%h ov=%b op=%h exp 0340/1/99", bus2.addr, bus2.operand_valid, bus2.operand); end
        tick();
        checks++; if (bus2.addr !== 16'h0001 || bus2.operand_valid !== 1'b0) begin failures++; $display("FAIL zp_next addr=%h ov=%b exp 0001/0", bus2.addr, bus2.operand_valid); end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_zpx();
        test_abs_indexed();
        test_rdy_stall();
        test_illegal();
        test_pc_wrap_zp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
